// File: rtl/misr_sig_engine.sv
// ============================================================================
// misr_sig_engine
// ----------------------------------------------------------------------------
// Multiple-input signature register (MISR) with run control. A run is
// started with a one-cycle start pulse. Each valid response word z is folded
// into the signature until num_pat words have been accepted. On completion
// the signature is compared with the golden value latched at start, and the
// result is presented on pass while done is high.
//
// Signature recurrence (Galois form, MSB feeds back):
//     sig_next = (sig << 1) ^ z ^ (sig[WIDTH-1] ? POLY : 0)
//
// Parameters
//   WIDTH  : signature / response width (4..64)
//   POLY   : feedback tap mask, bit i set = sig[WIDTH-1] XORed into stage i
//   SEED   : signature value loaded on start and on reset
//   CNT_W  : pattern counter width
//
// Ports
//   clk        in   single clock, all state updates on the rising edge
//   rst        in   asynchronous active-low reset
//   start      in   one-cycle pulse, begins a run (ignored while busy)
//   abort      in   one-cycle pulse, terminates a run (beats start/z_valid)
//   num_pat    in   number of responses to compress, sampled on start
//   golden     in   expected signature, sampled on start
//   z_valid    in   response word valid this cycle
//   z          in   response word
//   signature  out  current MISR contents
//   count      out  responses compressed in the current run
//   busy       out  high while a run is in progress
//   done       out  high once a run has completed
//   pass       out  valid while done; 1 = signature matched golden
// ============================================================================
module misr_sig_engine #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 'h63,
    parameter logic [WIDTH-1:0] SEED  = '0,
    parameter int               CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_pat,
    input  logic [WIDTH-1:0] golden,
    input  logic             z_valid,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] sig_q,     sig_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [CNT_W-1:0] num_pat_q, num_pat_d;
    logic [WIDTH-1:0] golden_q,  golden_d;
    logic             pass_q,    pass_d;

    // ------------------------------------------------------------------------
    // Signature recurrence, one XOR network per stage. Stage 0 has no shifted
    // predecessor; every other stage takes the bit below it.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] sig_next;
    logic             fb_bit;

    assign fb_bit = sig_q[WIDTH-1];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_stage
            if (gi == 0) begin : g_lsb
                assign sig_next[gi] = z[gi] ^ (fb_bit & POLY[gi]);
            end else begin : g_upper
                assign sig_next[gi] = sig_q[gi-1] ^ z[gi] ^ (fb_bit & POLY[gi]);
            end
        end
    endgenerate

    // Count after the accept in progress. Runs only enter RUN with a non-zero
    // target and leave on reaching it, so this sum never wraps.
    logic [CNT_W-1:0] cnt_inc;
    assign cnt_inc = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        sig_d     = sig_q;
        cnt_d     = cnt_q;
        num_pat_d = num_pat_q;
        golden_d  = golden_q;
        pass_d    = pass_q;

        if (abort) begin
            // Abort wins over everything else. Signature and count are left
            // as-is so the partial result can still be inspected.
            state_d = IDLE;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        sig_d     = SEED;
                        cnt_d     = '0;
                        num_pat_d = num_pat;
                        golden_d  = golden;
                        pass_d    = 1'b0;
                        if (num_pat == '0) begin
                            // Empty run: nothing to compress, so the verdict
                            // is just whether the seed is the golden value.
                            state_d = DONE;
                            pass_d  = (SEED == golden);
                        end else begin
                            state_d = RUN;
                        end
                    end
                end

                RUN: begin
                    if (z_valid) begin
                        sig_d = sig_next;
                        cnt_d = cnt_inc;
                        if (cnt_inc == num_pat_q) begin
                            // Verdict is taken on the freshly updated
                            // signature, so it is registered together with
                            // the DONE entry.
                            state_d = DONE;
                            pass_d  = (sig_next == golden_q);
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sig_q     <= SEED;
            cnt_q     <= '0;
            num_pat_q <= '0;
            golden_q  <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sig_q     <= sig_d;
            cnt_q     <= cnt_d;
            num_pat_q <= num_pat_d;
            golden_q  <= golden_d;
            pass_q    <= pass_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. pass_q is cleared on every start and abort, so it can only be
    // high while in DONE.
    // ------------------------------------------------------------------------
    assign signature = sig_q;
    assign count     = cnt_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;

endmodule

// File: doc/misr_sig_engine.md
MISR_SIG_ENGINE -- requirements
Module: misr_sig_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, signature and response width (legal 4..64).
REQ-002 SHALL have parameter POLY, default 8'h63 (x^8+x^6+x^5+x+1), feedback tap mask; bit i set = r[WIDTH-1] XORed into stage i.
REQ-003 SHALL have parameter SEED, default 0, signature value loaded on start.
REQ-004 SHALL have parameter CNT_W, default 16, pattern counter width.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle pulse, begins a compression run.
REQ-008 SHALL have port abort  input  1  one-cycle pulse, terminates a run.
REQ-009 SHALL have port num_pat  input  CNT_W  number of responses to compress, sampled on start.
REQ-010 SHALL have port golden  input  WIDTH  expected signature, sampled on start.
REQ-011 SHALL have port z_valid  input  1  response z valid this cycle.
REQ-012 SHALL have port z  input  WIDTH  circuit-under-test response word.
REQ-013 SHALL have port signature  output  WIDTH  current MISR contents.
REQ-014 SHALL have port count  output  CNT_W  responses compressed in the current run.
REQ-015 SHALL have port busy  output  1  high in RUN.
REQ-016 SHALL have port done  output  1  high in DONE.
REQ-017 SHALL have port pass  output  1  valid while done; 1 = signature matched golden.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-019 SHALL compute next signature = (sig << 1, truncated to WIDTH) XOR z XOR (sig[WIDTH-1] ? POLY : 0); with defaults this is bit-identical to the existing 8-bit MISR.
REQ-020 SHALL update signature only in RUN on cycles with z_valid=1; otherwise hold.
REQ-021 SHALL, on start in IDLE or DONE: load signature=SEED, count=0, latch num_pat and golden, clear pass; enter RUN, or enter DONE next cycle if num_pat=0.
REQ-022 SHALL ignore start while in RUN.
REQ-023 SHALL increment count by 1 per accepted z_valid in RUN; the accept that makes count equal latched num_pat moves the FSM to DONE on the same edge (latency: done high the cycle after the last accept).
REQ-024 SHALL, in DONE, drive pass = (signature == latched golden), registered on DONE entry, and hold signature, count, pass until the next start.
REQ-025 SHALL, on abort in RUN, return to IDLE with signature and count held, pass=0, done=0; abort in IDLE or DONE moves to IDLE with pass cleared.
REQ-026 SHALL give abort priority over start and z_valid in the same cycle.
REQ-027 SHALL not wrap count: num_pat up to 2^CNT_W-1 completes normally; z_valid in IDLE or DONE is ignored.
REQ-028 SHALL keep busy and done mutually exclusive; both low in IDLE.

Reset
REQ-029 SHALL, on rst=0 at any time including mid-run, asynchronously force state=IDLE, signature=SEED, count=0, busy=0, done=0, pass=0, latched num_pat=0, latched golden=0.
REQ-030 SHALL, on rst release, begin normal operation at the first rising clk edge with rst=1.

Verification
REQ-031 Defaults, start with num_pat=1, golden=8'h01, z=8'h01 valid one cycle -> signature=8'h01, count=1, done=1, pass=1.
REQ-032 Defaults, num_pat=2, golden=8'h63, z=8'h80 then 8'h00 (with a z_valid=0 gap between) -> signature 8'h80 then 8'h63, gap holds value, done=1, pass=1.
REQ-033 num_pat=0 start -> done=1 after one cycle, signature=SEED, count=0, pass=(SEED==golden).
REQ-034 num_pat=4, abort after 2 accepts with start and z_valid also high -> IDLE, count=2, pass=0, done=0; a second start reloads SEED and completes normally.
REQ-035 rst=0 mid-run for less than one clock period -> all outputs at reset values immediately, no clock edge required.
REQ-036 WIDTH=16, POLY=16'h100B, 1000 random z words -> signature matches a software model every cycle; a single flipped bit in golden -> pass=0.
